jtag_scan_master: RTL

Hardware JTAG master that sequences a 4-bit-IR JTAG TAP (IDCODE default, BYPASS at 4'b1111) from a simple command/response interface. It generates TCK/TMS/TDI, captures TDO, and tracks the TAP state so that every command starts and ends in Select-DR-Scan. It sits between on-chip control logic and the TAP pins of `top`, replacing bench-driven pin wiggling for self-test and boundary access.

---
 rtl/jtag_master_pkg.sv | 24 ++
 rtl/jtag_scan_master_if.sv | 25 ++
 rtl/jtag_tck_gen.sv | 37 +++
 rtl/jtag_scan_master.sv | 134 +++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - shared types and constants for the JTAG scan master
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_IR_SCAN = 2'd1,
        OP_DR_SCAN = 2'd2,
        OP_RSVD    = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } state_t;

    localparam logic [3:0] IDCODE_IR = 4'b0010;
    localparam logic [3:0] BYPASS_IR = 4'b1111;

    // Applied LSB first: five ones reach Test-Logic-Reset from anywhere, then 0,1 to Select-DR-Scan
    localparam logic [6:0] RESET_TMS  = 7'b1011111;
    localparam int         RESET_BITS = 7;

endpackage

// File: rtl/jtag_scan_master_if.sv
// rtl/jtag_scan_master_if.sv - command/response handshake bundle for the JTAG scan master
interface jtag_scan_master_if #(
    parameter int MAX_DR_BITS = 64,
    parameter int LW          = $clog2(MAX_DR_BITS + 1)
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [LW-1:0]          cmd_len;
    logic [MAX_DR_BITS-1:0] cmd_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [MAX_DR_BITS-1:0] rsp_data;
    logic                   rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - gated TCK divider with one-cycle rise/fall strobes
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic trst_,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam int PW = $clog2(2 * TCK_DIV);
    localparam logic [PW-1:0] PH_RISE = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_DIV - 1);

    logic [PW-1:0] ph_q;

    // Strobes flag the cycle whose closing edge moves tck
    assign rise = en && (ph_q == PH_RISE);
    assign fall = en && (ph_q == PH_LAST);

    always_ff @(posedge clk or posedge trst_) begin
        if (trst_) begin
            ph_q <= '0;
            tck  <= 1'b0;
        end else if (!en) begin
            ph_q <= '0;
            tck  <= 1'b0;
        end else begin
            ph_q <= fall ? '0 : ph_q + PW'(1);
            if (rise)
                tck <= 1'b1;
            else if (fall)
                tck <= 1'b0;
        end
    end
endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG master sequencing a TAP from command/response handshakes
module jtag_scan_master
    import jtag_master_pkg::*;
#(
    parameter int IR_LENGTH   = 4,
    parameter int MAX_DR_BITS = 64,
    parameter int TCK_DIV     = 2,
    parameter int LW          = $clog2(MAX_DR_BITS + 1)
) (
    input  logic              clk,
    input  logic              trst_,
    jtag_scan_master_if.slave bus,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);
    localparam int BW = LW + 3;
    localparam logic [BW-1:0] ONE = BW'(1);

    state_t                 state_q, state_d;
    cmd_op_t                cmd_op, op_q, sel_op;
    logic [BW-1:0]          bit_q, last_q, pre_q, slen_q;
    logic [BW-1:0]          new_pre, new_slen, new_last, sel_pre, sel_slen, k_nx;
    logic [MAX_DR_BITS-1:0] data_q, cap_q;
    logic                   err_q, tap_known_q;
    logic                   rise, fall, accept, reject, last_bit, in_shift, shift_nx, tms_nx;

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk  (clk),
        .trst_(trst_),
        .en   (state_q == ST_RUN),
        .tck  (tck),
        .rise (rise),
        .fall (fall)
    );

    assign cmd_op = cmd_op_t'(bus.cmd_op);
    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;
    assign reject = (cmd_op == OP_RSVD)
                 || ((cmd_op == OP_DR_SCAN) && ((bus.cmd_len == '0) || (bus.cmd_len > LW'(MAX_DR_BITS))))
                 || ((cmd_op != OP_RESET) && !tap_known_q);

    // A scan is pre bits (to Shift-xR), slen shift bits, then two exit bits back to Select-DR-Scan
    assign new_pre  = (cmd_op == OP_IR_SCAN) ? BW'(3) : (cmd_op == OP_DR_SCAN) ? BW'(2) : '0;
    assign new_slen = (cmd_op == OP_IR_SCAN) ? BW'(IR_LENGTH) :
                      (cmd_op == OP_DR_SCAN) ? BW'(bus.cmd_len) : '0;
    assign new_last = (cmd_op == OP_RESET) ? BW'(RESET_BITS - 1) : new_pre + new_slen + ONE;

    assign last_bit = (bit_q == last_q);
    assign in_shift = (bit_q >= pre_q) && (bit_q < pre_q + slen_q);

    assign sel_op   = (state_q == ST_IDLE) ? cmd_op   : op_q;
    assign sel_pre  = (state_q == ST_IDLE) ? new_pre  : pre_q;
    assign sel_slen = (state_q == ST_IDLE) ? new_slen : slen_q;
    assign k_nx     = (state_q == ST_IDLE) ? '0 : bit_q + ONE;
    assign shift_nx = (k_nx >= sel_pre) && (k_nx < sel_pre + sel_slen);

    always_comb begin
        tms_nx = 1'b1;
        if (sel_op == OP_RESET)
            tms_nx = RESET_TMS[k_nx[2:0]];
        else if (k_nx < sel_pre)
            tms_nx = (sel_op == OP_IR_SCAN) && (k_nx == '0);
        else if (shift_nx)
            tms_nx = (k_nx == sel_pre + sel_slen - ONE);
    end

    always_ff @(posedge clk or posedge trst_) begin
        if (trst_)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid)  state_d = reject ? ST_RESP : ST_RUN;
            ST_RUN:  if (fall && last_bit) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge trst_) begin
        if (trst_) begin
            op_q        <= OP_RESET;
            bit_q       <= '0;
            last_q      <= '0;
            pre_q       <= '0;
            slen_q      <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            err_q       <= 1'b0;
            tap_known_q <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
        end else if (accept) begin
            op_q   <= cmd_op;
            pre_q  <= new_pre;
            slen_q <= new_slen;
            last_q <= new_last;
            data_q <= bus.cmd_data;
            cap_q  <= '0;
            err_q  <= reject;
            bit_q  <= '0;
            if (!reject) begin
                tms <= tms_nx;
                tdi <= 1'b0;
            end
            if (!reject && (cmd_op == OP_RESET))
                tap_known_q <= 1'b1;
        end else if (state_q == ST_RUN) begin
            // Capture enters at the top; the final right-align puts the first TDO bit at LSB
            if (rise && in_shift)
                cap_q <= {tdo, cap_q[MAX_DR_BITS-1:1]};
            if (fall && last_bit)
                cap_q <= cap_q >> (BW'(MAX_DR_BITS) - slen_q);
            if (fall && !last_bit) begin
                bit_q <= bit_q + ONE;
                tms   <= tms_nx;
                tdi   <= shift_nx & data_q[0];
                if (shift_nx)
                    data_q <= data_q >> 1;
            end
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = cap_q;
    assign bus.rsp_err   = err_q;
endmodule
